// File: rtl/ripple_carry.sv
// WIDTH-bit ripple-carry adder with a combinational result and a registered copy (incl. signed overflow).
// Optional macro RIPPLE_CARRY_CARRY_CHAIN_EN exposes the internal carry chain as output c_chain.
module ripple_carry #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] sum_q,
    output logic             c_out_q,
    output logic             ovf_q
`ifdef RIPPLE_CARRY_CARRY_CHAIN_EN
    ,
    output logic [WIDTH:0]   c_chain
`endif
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    logic             ovf;

    assign c[0] = cin;

    // One full-adder cell per bit; carry ripples from bit 0 upward.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign sum   = s;
    assign c_out = c[WIDTH];
    assign ovf   = c[WIDTH] ^ c[WIDTH-1];

`ifdef RIPPLE_CARRY_CARRY_CHAIN_EN
    assign c_chain = c;
`endif

    // Registered copy for pipelined consumers; reset clears it immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sum_q   <= sum;
            c_out_q <= c_out;
            ovf_q   <= ovf;
        end
    end

endmodule

// File: tb/tb_ripple_carry.sv
// Self-checking bench for ripple_carry: exhaustive sweep, directed corners, random vs arithmetic model.
// Build with RIPPLE_CARRY_CARRY_CHAIN_EN defined to also check c_chain.
module tb_ripple_carry;

    localparam int unsigned W = 4;

    logic [W-1:0] a, b, sum, sum_q;
    logic         cin, c_out, clk, rst_n, c_out_q, ovf_q;
`ifdef RIPPLE_CARRY_CARRY_CHAIN_EN
    logic [W:0]   c_chain;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ripple_carry #(.WIDTH(W)) dut (
        .a       (a),
        .b       (b),
        .cin     (cin),
        .sum     (sum),
        .c_out   (c_out),
        .clk     (clk),
        .rst_n   (rst_n),
        .sum_q   (sum_q),
        .c_out_q (c_out_q),
        .ovf_q   (ovf_q)
`ifdef RIPPLE_CARRY_CARRY_CHAIN_EN
        ,
        .c_chain (c_chain)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: unsigned sum of operands as plain integers.
    function automatic logic [W:0] model_add(input int x, input int y, input int ci);
        return (W+1)'(x + y + ci);
    endfunction

    // Reference: signed overflow = true signed result outside the W-bit two's complement range.
    function automatic logic model_ovf(input int x, input int y, input int ci);
        int sx, sy, r;
        sx = (x >= (1 << (W-1))) ? x - (1 << W) : x;
        sy = (y >= (1 << (W-1))) ? y - (1 << W) : y;
        r  = sx + sy + ci;
        return (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
    endfunction

    // Reference: carry into bit i is what overflows from adding the low i bits.
    function automatic logic [W:0] model_chain(input int x, input int y, input int ci);
        logic [W:0] ch;
        ch = '0;
        for (int i = 0; i <= int'(W); i++) begin
            int m;
            m = (1 << i) - 1;
            ch[i] = (((x & m) + (y & m) + ci) >> i) & 1;
        end
        return ch;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int x, input int y, input int ci);
        @(negedge clk);
        a   = W'(x);
        b   = W'(y);
        cin = 1'(ci);
        #1;
    endtask

    task automatic check_comb(input string tag, input int x, input int y, input int ci);
        check(tag, 64'({c_out, sum}), 64'(model_add(x, y, ci)));
`ifdef RIPPLE_CARRY_CARRY_CHAIN_EN
        check({tag, "_chain"}, 64'(c_chain), 64'(model_chain(x, y, ci)));
`endif
    endtask

    task automatic check_reg(input string tag, input int x, input int y, input int ci);
        check({tag, "_sum_q"}, 64'({c_out_q, sum_q}), 64'(model_add(x, y, ci)));
        check({tag, "_ovf_q"}, 64'(ovf_q), 64'(model_ovf(x, y, ci)));
    endtask

    initial begin
        int x, y, ci;
        rst_n = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        #2;
        check("rst_sum_q", 64'(sum_q), 64'(0));
        check("rst_c_out_q", 64'(c_out_q), 64'(0));
        check("rst_ovf_q", 64'(ovf_q), 64'(0));
        // Combinational path works while reset is held.
        a = 4'd9; b = 4'd8; #1;
        check("rst_comb_9p8", 64'({c_out, sum}), 64'(5'b1_0001));
        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive cin=0 sweep, one 10-unit step per pair.
        for (int i = 0; i < (1 << W); i++) begin
            for (int j = 0; j < (1 << W); j++) begin
                drive(i, j, 0);
                check_comb("sweep", i, j, 0);
            end
        end

        drive(15, 0, 1);
        check("cin_15p0", 64'({c_out, sum}), 64'(5'b1_0000));
        drive(7, 7, 1);
        check("cin_7p7", 64'({c_out, sum}), 64'(5'b0_1111));
        drive(15, 15, 1);
        check("wrap_max", 64'({c_out, sum}), 64'(5'b1_1111));

        // Full ripple within one time step.
        drive(15, 0, 0);
        check("ripple_pre", 64'({c_out, sum}), 64'(5'b0_1111));
        cin = 1'b1;
        #1;
        check("ripple_post", 64'({c_out, sum}), 64'(5'b1_0000));

        drive(3, 4, 0);
        @(posedge clk); #1;
        check("reg_3p4", 64'({ovf_q, c_out_q, sum_q}), 64'(6'b0_0_0111));

        drive(7, 1, 0);
        @(posedge clk); #1;
        check("reg_ovf_7p1", 64'({ovf_q, c_out_q, sum_q}), 64'(6'b1_0_1000));

        // Async reset between edges clears registers at once, leaves comb outputs alone.
        rst_n = 1'b0;
        #1;
        check("arst_regs", 64'({ovf_q, c_out_q, sum_q}), 64'(0));
        check("arst_comb", 64'({c_out, sum}), 64'(5'b0_1000));
        @(posedge clk); #1;
        check("arst_hold", 64'({ovf_q, c_out_q, sum_q}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst_reload", 64'({ovf_q, c_out_q, sum_q}), 64'(6'b1_0_1000));

        // Random operands against the arithmetic model, comb and one-cycle registered.
        for (int k = 0; k < 300; k++) begin
            x  = int'($urandom_range((1 << W) - 1, 0));
            y  = int'($urandom_range((1 << W) - 1, 0));
            ci = int'($urandom_range(1, 0));
            drive(x, y, ci);
            check_comb("rand_comb", x, y, ci);
            @(posedge clk); #1;
            check_reg("rand_reg", x, y, ci);
        end

`ifdef RIPPLE_CARRY_CARRY_CHAIN_EN
        drive(5, 3, 0);
        check("chain_5p3", 64'(c_chain), 64'(5'b01110));
        check("chain_5p3_sum", 64'({c_out, sum}), 64'(5'b0_1000));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
